// File: rtl/stopwatch_counter.sv
// MM:SS BCD time-keeping core: run/pause FSM, 1 Hz counting with rollover,
// and 2 Hz stepping of the selected field in adjust mode.
module stopwatch_counter #(
   parameter int unsigned WRAP_MIN = 59
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_1hz,
   input  logic       tick_2hz,
   input  logic       pause,
   input  logic       adj,
   input  logic       sel,
   output logic [2:0] min1,
   output logic [3:0] min2,
   output logic [2:0] sec1,
   output logic [3:0] sec2,
   output logic       running,
   output logic       rollover
);

   localparam int unsigned TW = 3;
   localparam int unsigned UW = 4;
   localparam logic [TW-1:0] WRAP_TENS  = TW'(WRAP_MIN / 10);
   localparam logic [UW-1:0] WRAP_UNITS = UW'(WRAP_MIN % 10);

   typedef enum logic {
      PAUSED = 1'b0,
      RUN    = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [TW-1:0] r_min1, r_sec1;
   logic [UW-1:0] r_min2, r_sec2;
   logic          r_running;
   logic          r_rollover;

   logic          w_run_tick;
   logic          w_adj_sec;
   logic          w_adj_min;
   logic          w_sec_wrap;
   logic          w_min_wrap;
   logic [TW-1:0] w_min1_inc, w_sec1_inc;
   logic [UW-1:0] w_min2_inc, w_sec2_inc;

   // Run-state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= PAUSED;
      else       r_state <= w_state_nxt;
   end

   // Each pause pulse toggles; adjust mode leaves the state alone
   always_comb begin
      w_state_nxt = r_state;
      if (pause) w_state_nxt = (r_state == RUN) ? PAUSED : RUN;
   end

   // Decode which tick acts this cycle, judged against the current state
   always_comb begin
      w_run_tick = 1'b0;
      w_adj_sec  = 1'b0;
      w_adj_min  = 1'b0;
      if (adj) begin
         w_adj_sec = tick_2hz & sel;
         w_adj_min = tick_2hz & ~sel;
      end else begin
         w_run_tick = tick_1hz & (r_state == RUN);
      end
   end

   // Per-field BCD incrementers with wrap
   always_comb begin
      w_sec_wrap = (r_sec1 == 3'd5) && (r_sec2 == 4'd9);
      w_min_wrap = (r_min1 == WRAP_TENS) && (r_min2 == WRAP_UNITS);
      w_sec1_inc = r_sec1;
      w_sec2_inc = r_sec2 + 4'd1;
      if (r_sec2 == 4'd9) begin
         w_sec2_inc = '0;
         w_sec1_inc = (r_sec1 == 3'd5) ? '0 : r_sec1 + 3'd1;
      end
      w_min1_inc = r_min1;
      w_min2_inc = r_min2 + 4'd1;
      if (w_min_wrap) begin
         w_min1_inc = '0;
         w_min2_inc = '0;
      end else if (r_min2 == 4'd9) begin
         w_min2_inc = '0;
         w_min1_inc = r_min1 + 3'd1;
      end
   end

   // Digit registers and status outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         r_min1     <= '0;
         r_min2     <= '0;
         r_sec1     <= '0;
         r_sec2     <= '0;
         r_running  <= 1'b0;
         r_rollover <= 1'b0;
      end else begin
         r_running  <= (w_state_nxt == RUN);
         r_rollover <= 1'b0;
         if (w_run_tick) begin
            r_sec1 <= w_sec1_inc;
            r_sec2 <= w_sec2_inc;
            if (w_sec_wrap) begin
               r_min1     <= w_min1_inc;
               r_min2     <= w_min2_inc;
               r_rollover <= w_min_wrap;
            end
         end else if (w_adj_sec) begin
            r_sec1 <= w_sec1_inc;
            r_sec2 <= w_sec2_inc;
         end else if (w_adj_min) begin
            r_min1 <= w_min1_inc;
            r_min2 <= w_min2_inc;
         end
      end
   end

   assign min1     = r_min1;
   assign min2     = r_min2;
   assign sec1     = r_sec1;
   assign sec2     = r_sec2;
   assign running  = r_running;
   assign rollover = r_rollover;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; times compared as decimal MMSS.
module tb_stopwatch_counter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       tick_2hz = 1'b0;
   logic       pause = 1'b0;
   logic       adj = 1'b0;
   logic       sel = 1'b0;
   logic [2:0] min1, sec1;
   logic [3:0] min2, sec2;
   logic       running, rollover;

   int checks = 0;
   int failures = 0;
   int roll_seen = 0;

   stopwatch_counter #(.WRAP_MIN(59)) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
      .pause(pause), .adj(adj), .sel(sel),
      .min1(min1), .min2(min2), .sec1(sec1), .sec2(sec2),
      .running(running), .rollover(rollover)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rollover) roll_seen++;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int mmss();
      return int'(min1) * 1000 + int'(min2) * 100 + int'(sec1) * 10 + int'(sec2);
   endfunction

   // One clock with the given pulses applied, then pulses cleared
   task automatic step(input logic p, input logic t1, input logic t2);
      pause = p; tick_1hz = t1; tick_2hz = t2;
      @(posedge clk); #1;
      pause = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;
   endtask

   task automatic ticks1(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
   endtask

   task automatic ticks2(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      // Reset and start
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      check("reset_time", mmss(), 0);
      check("reset_running", int'(running), 0);
      check("reset_rollover", int'(rollover), 0);
      step(1'b1, 1'b0, 1'b0);
      check("start_running", int'(running), 1);
      ticks1(61);
      check("count_61", mmss(), 101);

      // Full wrap
      ticks1(3537);
      check("preload_5958", mmss(), 5958);
      check("no_roll_before_wrap", roll_seen, 0);
      ticks1(1);
      check("time_5959", mmss(), 5959);
      check("roll_at_5959", int'(rollover), 0);
      ticks1(1);
      check("wrap_time", mmss(), 0);
      check("wrap_rollover", int'(rollover), 1);
      step(1'b0, 1'b0, 1'b0);
      check("rollover_drop", int'(rollover), 0);
      check("rollover_count", roll_seen, 1);

      // Pause hold
      ticks1(10);
      check("run_0010", mmss(), 10);
      step(1'b1, 1'b0, 1'b0);
      check("paused_running", int'(running), 0);
      ticks1(5);
      check("paused_hold", mmss(), 10);
      step(1'b1, 1'b0, 1'b0);
      ticks1(1);
      check("resume_0011", mmss(), 11);
      check("resume_running", int'(running), 1);

      // Adjust seconds
      ticks1(767);
      check("preload_1258", mmss(), 1258);
      adj = 1'b1; sel = 1'b1;
      step(1'b0, 1'b0, 1'b1);
      check("adj_sec_1259", mmss(), 1259);
      step(1'b0, 1'b1, 1'b0);
      check("adj_ignores_1hz", mmss(), 1259);
      step(1'b0, 1'b0, 1'b1);
      check("adj_sec_wrap", mmss(), 1200);
      step(1'b0, 1'b1, 1'b1);
      check("adj_sec_1201", mmss(), 1201);
      check("adj_rollover", int'(rollover), 0);
      check("adj_keeps_run", int'(running), 1);

      // Adjust minutes
      ticks2(29);
      sel = 1'b0;
      ticks2(46);
      check("preload_5830", mmss(), 5830);
      step(1'b0, 1'b0, 1'b1);
      check("adj_min_5930", mmss(), 5930);
      step(1'b0, 1'b0, 1'b1);
      check("adj_min_wrap", mmss(), 30);
      check("adj_min_no_roll", roll_seen, 1);
      adj = 1'b0;
      ticks1(1);
      check("resume_after_adj", mmss(), 31);

      // Simultaneous events
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      ticks1(5);
      check("preload_0005", mmss(), 5);
      step(1'b1, 1'b1, 1'b0);
      check("pause_tick_run_time", mmss(), 6);
      check("pause_tick_run_state", int'(running), 0);
      step(1'b1, 1'b1, 1'b0);
      check("pause_tick_paused_time", mmss(), 6);
      check("pause_tick_paused_state", int'(running), 1);
      reset = 1'b1;
      adj = 1'b1;
      step(1'b1, 1'b1, 1'b1);
      reset = 1'b0;
      adj = 1'b0;
      check("reset_prio_time", mmss(), 0);
      check("reset_prio_running", int'(running), 0);
      ticks1(3);
      check("reset_stays_paused", mmss(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
